// File: rtl/ntt_stream_bridge.sv
// ntt_stream_bridge
//   Streams one transform's worth of packed {addr, coefficient} words into an
//   NTT core over LANES parallel write ports, pulses the core start, then
//   captures the core's result beats into a small buffer that the host drains
//   with a valid/ready handshake.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   go, mode        start request (IDLE only) and forward/inverse select
//   in_data         LANES packed {addr, data} words; lane k at k*(ADDR_W+DATA_W)
//   in_valid/ready  load handshake
//   core_we/addr/din per-lane write port into the core
//   core_mode       mode latched at go
//   core_start      one-cycle start pulse
//   core_out_valid  result beat present on core_dout (core cannot stall)
//   out_data        buffer head, show-ahead
//   out_valid/ready unload handshake
//   busy, done      not-idle flag, one-cycle completion pulse
//   overflow        sticky: a result beat was dropped because the buffer was full
module ntt_stream_bridge #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 8,
  parameter int LANES      = 2,
  parameter int N_COEF     = 256,
  parameter int OBUF_DEPTH = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           go,
  input  logic                           mode,
  input  logic [LANES*(ADDR_W+DATA_W)-1:0] in_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [LANES-1:0]               core_we,
  output logic [LANES*ADDR_W-1:0]        core_addr,
  output logic [LANES*DATA_W-1:0]        core_din,
  output logic                           core_mode,
  output logic                           core_start,
  input  logic                           core_out_valid,
  input  logic [LANES*DATA_W-1:0]        core_dout,
  output logic [LANES*DATA_W-1:0]        out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           busy,
  output logic                           done,
  output logic                           overflow
);

  localparam int LW     = ADDR_W + DATA_W;
  localparam int BEATS  = N_COEF / LANES;
  localparam int CNT_W  = $clog2(BEATS + 1);
  localparam int IDX_W  = $clog2(OBUF_DEPTH);
  localparam int PTR_W  = IDX_W + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t state;

  logic [CNT_W-1:0] load_cnt;
  logic [CNT_W-1:0] res_cnt;

  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LANES*DATA_W-1:0] obuf [OBUF_DEPTH];

  logic empty;
  logic full;
  logic pop;
  logic push;

  // Split the packed input words into per-lane address and data vectors.
  logic [LANES*ADDR_W-1:0] lane_addr;
  logic [LANES*DATA_W-1:0] lane_din;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign lane_addr[gi*ADDR_W +: ADDR_W] = in_data[gi*LW + DATA_W +: ADDR_W];
      assign lane_din[gi*DATA_W +: DATA_W]  = in_data[gi*LW +: DATA_W];
    end
  endgenerate

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                 (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);

  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;

  // A write into a full buffer still succeeds when the head leaves the same
  // cycle, so occupancy is unchanged rather than the beat being dropped.
  assign push = (state == S_RUN) && core_out_valid && (!full || pop);

  // Show-ahead head: read is asynchronous so the head is visible as soon as
  // out_valid rises; gated to zero while empty so the idle value is defined.
  assign out_data = out_valid ? obuf[rd_ptr[IDX_W-1:0]] : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      obuf[wr_ptr[IDX_W-1:0]] <= core_dout;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      in_ready   <= 1'b0;
      core_we    <= '0;
      core_addr  <= '0;
      core_din   <= '0;
      core_mode  <= 1'b0;
      core_start <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      load_cnt   <= '0;
      res_cnt    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      core_we    <= '0;
      core_start <= 1'b0;
      done       <= 1'b0;

      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (go) begin
            state     <= S_LOAD;
            in_ready  <= 1'b1;
            busy      <= 1'b1;
            core_mode <= mode;
            overflow  <= 1'b0;
            load_cnt  <= '0;
            res_cnt   <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
          end
        end

        S_LOAD: begin
          if (in_valid && in_ready) begin
            core_we   <= '1;
            core_addr <= lane_addr;
            core_din  <= lane_din;
            load_cnt  <= load_cnt + 1'b1;
            // in_ready falls on the same edge that takes the final beat.
            if (load_cnt == LAST_BEAT) begin
              state    <= S_START;
              in_ready <= 1'b0;
            end
          end
        end

        // One idle cycle here places core_start just after the last write.
        S_START: begin
          core_start <= 1'b1;
          state      <= S_RUN;
        end

        S_RUN: begin
          if (core_out_valid) begin
            res_cnt <= res_cnt + 1'b1;
            if (push) begin
              wr_ptr <= wr_ptr + 1'b1;
            end else begin
              overflow <= 1'b1;
            end
            if (res_cnt == LAST_BEAT) begin
              state <= S_DRAIN;
            end
          end
        end

        S_DRAIN: begin
          if (empty) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ntt_stream_bridge.sv
// tb_ntt_stream_bridge
//   Drives whole transforms through the bridge with directed and $urandom
//   stimulus and compares every output, every cycle, against a transaction
//   level reference (expected write beats from lookup tables, a queue for the
//   output buffer). Prints one line per finished transform and a summary.
module tb_ntt_stream_bridge;

  localparam int DATA_W     = 16;
  localparam int ADDR_W     = 8;
  localparam int LANES      = 2;
  localparam int N_COEF     = 10;
  localparam int OBUF_DEPTH = 4;
  localparam int BEATS      = N_COEF / LANES;
  localparam int LW         = ADDR_W + DATA_W;
  localparam int MAX_CYC    = 400;

  logic                      clk = 1'b0;
  logic                      rst = 1'b0;
  logic                      go = 1'b0;
  logic                      mode = 1'b0;
  logic [LANES*LW-1:0]       in_data = '0;
  logic                      in_valid = 1'b0;
  logic                      in_ready;
  logic [LANES-1:0]          core_we;
  logic [LANES*ADDR_W-1:0]   core_addr;
  logic [LANES*DATA_W-1:0]   core_din;
  logic                      core_mode;
  logic                      core_start;
  logic                      core_out_valid = 1'b0;
  logic [LANES*DATA_W-1:0]   core_dout = '0;
  logic [LANES*DATA_W-1:0]   out_data;
  logic                      out_valid;
  logic                      out_ready = 1'b0;
  logic                      busy;
  logic                      done;
  logic                      overflow;

  always #5 clk = ~clk;

  ntt_stream_bridge #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LANES(LANES),
    .N_COEF(N_COEF), .OBUF_DEPTH(OBUF_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .go(go), .mode(mode),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .core_we(core_we), .core_addr(core_addr), .core_din(core_din),
    .core_mode(core_mode), .core_start(core_start),
    .core_out_valid(core_out_valid), .core_dout(core_dout),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .overflow(overflow)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum int {P_IDLE, P_LOAD, P_START, P_RUN, P_DRAIN} phase_t;

  phase_t                  ph;
  int                      acc;
  int                      res;
  logic [LANES*DATA_W-1:0] q[$];
  logic                    m_ovf, m_mode, m_we, m_start, m_done;
  logic [LANES*ADDR_W-1:0] m_addr;
  logic [LANES*DATA_W-1:0] m_din;

  logic [ADDR_W-1:0] addr_tab [BEATS][LANES];
  logic [DATA_W-1:0] data_tab [BEATS][LANES];
  logic [DATA_W-1:0] res_tab  [BEATS][LANES];

  function automatic logic [LANES*LW-1:0] in_word(input int b);
    logic [LANES*LW-1:0] w;
    w = '0;
    for (int k = 0; k < LANES; k++) w[k*LW +: LW] = {addr_tab[b][k], data_tab[b][k]};
    return w;
  endfunction

  function automatic logic [LANES*DATA_W-1:0] res_word(input int b);
    logic [LANES*DATA_W-1:0] w;
    w = '0;
    for (int k = 0; k < LANES; k++) w[k*DATA_W +: DATA_W] = res_tab[b][k];
    return w;
  endfunction

  task automatic model_reset();
    ph = P_IDLE; acc = 0; res = 0; q.delete();
    m_ovf = 0; m_mode = 0; m_we = 0; m_start = 0; m_done = 0;
    m_addr = '0; m_din = '0;
  endtask

  // Applies one clock edge's worth of behaviour using the inputs the bench
  // presented to that edge.
  task automatic model_edge();
    int  occ;
    bit  pop;
    occ = q.size();
    m_we = 0; m_start = 0; m_done = 0;
    pop = (occ != 0) && out_ready;
    if (pop) void'(q.pop_front());
    case (ph)
      P_IDLE: if (go) begin
        ph = P_LOAD; m_mode = mode; m_ovf = 0; acc = 0; res = 0; q.delete();
      end
      P_LOAD: if (in_valid) begin
        m_we = 1;
        for (int k = 0; k < LANES; k++) begin
          m_addr[k*ADDR_W +: ADDR_W] = addr_tab[acc][k];
          m_din[k*DATA_W +: DATA_W]  = data_tab[acc][k];
        end
        acc++;
        if (acc == BEATS) ph = P_START;
      end
      P_START: begin m_start = 1; ph = P_RUN; end
      P_RUN: if (core_out_valid) begin
        if (occ < OBUF_DEPTH || pop) q.push_back(core_dout);
        else m_ovf = 1;
        res++;
        if (res == BEATS) ph = P_DRAIN;
      end
      P_DRAIN: if (occ == 0) begin m_done = 1; ph = P_IDLE; end
      default: ;
    endcase
  endtask

  task automatic check_outputs();
    check_eq("in_ready", in_ready, ph == P_LOAD);
    check_eq("core_we", core_we, m_we ? {LANES{1'b1}} : '0);
    check_eq("core_addr", core_addr, m_addr);
    check_eq("core_din", core_din, m_din);
    check_eq("core_mode", core_mode, m_mode);
    check_eq("core_start", core_start, m_start);
    check_eq("busy", busy, ph != P_IDLE);
    check_eq("done", done, m_done);
    check_eq("overflow", overflow, m_ovf);
    check_eq("out_valid", out_valid, q.size() != 0);
    check_eq("out_data", out_data, (q.size() != 0) ? q[0] : '0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    go = 0; in_valid = 0; core_out_valid = 0; out_ready = 0;
    #1 rst = 1;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    rst = 0;
  endtask

  // vmode: 0 in_valid every other cycle, 1 always, 2 random
  // rmode: 0 out_ready=1, 1 only in DRAIN, 2 DRAIN plus the final result beat, 3 random
  // cmode: 0 core_out_valid always, 1 random
  task automatic run_xfer(input int vmode, input int rmode, input int cmode,
                          input bit directed, input bit m, input int abort_at);
    int cyc;
    int done_cnt;
    for (int b = 0; b < BEATS; b++) begin
      for (int k = 0; k < LANES; k++) begin
        if (directed) begin
          addr_tab[b][k] = ADDR_W'(b * LANES + k);
          data_tab[b][k] = DATA_W'(16'h0100 + b * LANES + k);
          res_tab[b][k]  = DATA_W'(16'h00A0 + b + 16 * k);
        end else begin
          addr_tab[b][k] = ADDR_W'($urandom);
          data_tab[b][k] = DATA_W'($urandom);
          res_tab[b][k]  = DATA_W'($urandom);
        end
      end
    end
    go = 1; mode = m; in_valid = 0; core_out_valid = 0; out_ready = 0;
    step();
    go = 0; mode = ~m;
    cyc = 0;
    done_cnt = 0;
    while (ph != P_IDLE && cyc < MAX_CYC) begin
      if (abort_at > 0 && ph == P_LOAD && acc == abort_at) begin
        do_reset();
        $display("xfer abort: reset after %0d load beats", abort_at);
        return;
      end
      case (vmode)
        0:       in_valid = (cyc % 2 == 1);
        1:       in_valid = 1;
        default: in_valid = $urandom_range(0, 1);
      endcase
      in_data        = in_word(acc < BEATS ? acc : 0);
      core_out_valid = (cmode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
      core_dout      = res_word(res < BEATS ? res : 0);
      case (rmode)
        0:       out_ready = 1;
        1:       out_ready = (ph == P_DRAIN);
        2:       out_ready = (ph == P_DRAIN) ||
                             (ph == P_RUN && core_out_valid && res == BEATS - 1);
        default: out_ready = $urandom_range(0, 1);
      endcase
      go   = $urandom_range(0, 3) == 0;
      mode = $urandom_range(0, 1);
      step();
      if (done) done_cnt++;
      cyc++;
    end
    go = 0; in_valid = 0; core_out_valid = 0;
    check_eq("xfer_timeout", cyc < MAX_CYC, 1'b1);
    check_eq("done_count", done_cnt, 1);
    $display("xfer mode=%0d v=%0d r=%0d c=%0d cycles=%0d done=%0d overflow=%0d",
             m, vmode, rmode, cmode, cyc, done_cnt, overflow);
    if (cyc >= MAX_CYC) do_reset();
  endtask

  initial begin
    model_reset();
    do_reset();
    @(posedge clk); #1;
    check_outputs();

    // Directed: toggled in_valid, sequential addresses, inverse mode.
    run_xfer(0, 0, 0, 1'b1, 1'b1, 0);
    check_eq("mode_latched", core_mode, 1'b1);

    // Buffer held back: fifth beat must be dropped.
    run_xfer(1, 1, 0, 1'b1, 1'b0, 0);
    check_eq("ovf_dropped", overflow, 1'b1);

    // Same, but the head leaves on the fifth beat: nothing dropped.
    run_xfer(1, 2, 0, 1'b0, 1'b1, 0);
    check_eq("ovf_simultaneous", overflow, 1'b0);

    // Reset in the middle of loading, then a clean restart.
    run_xfer(1, 0, 0, 1'b1, 1'b1, 2);
    check_eq("abort_busy", busy, 1'b0);
    run_xfer(2, 3, 1, 1'b0, 1'b0, 0);

    for (int i = 0; i < 10; i++) begin
      run_xfer(2, 3, 1, 1'b0, 1'($urandom_range(0, 1)), 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ntt_stream_bridge.md
# ntt_stream_bridge

Single-clock, parametrised streaming bridge between the host-side word streams and the NTT core's coefficient ports. It loads one transform's worth of packed {address, coefficient} words into the core over LANES parallel write ports, fires the core, and captures the result beats into an internal output buffer drained by a valid/ready handshake. It generalises the fixed two-lane, 16-bit load/unload path to arbitrary lane count, widths and transform length, and adds backpressure, beat counting, overflow detection and a completion pulse.

## Interface
- DATA_W, 16: coefficient width.
- ADDR_W, 8: core address width.
- LANES, 2: parallel coefficient lanes per beat (≥1).
- N_COEF, 256: coefficients per transform; multiple of LANES, ≤ 2^ADDR_W. BEATS = N_COEF/LANES.
- OBUF_DEPTH, 16: output buffer entries (power of two, ≥2).
- clk  in  1  clock; all logic rises on this edge.
- rst  in  1  asynchronous, active-high reset.
- go  in  1  start a transform; honoured only in IDLE.
- mode  in  1  0 forward, 1 inverse; sampled with go.
- in_data  in  LANES*(ADDR_W+DATA_W)  lane k at bits [k*(ADDR_W+DATA_W) +: ADDR_W+DATA_W], packed {addr, data}.
- in_valid / in_ready  in / out  1  load handshake.
- core_we  out  LANES  per-lane write enable.
- core_addr  out  LANES*ADDR_W  per-lane address.
- core_din  out  LANES*DATA_W  per-lane coefficient.
- core_mode  out  1  latched mode.
- core_start  out  1  one-cycle start pulse.
- core_out_valid  in  1  result beat present (core cannot be stalled).
- core_dout  in  LANES*DATA_W  result beat.
- out_data  out  LANES*DATA_W  buffer head (show-ahead).
- out_valid / out_ready  out / in  1  unload handshake.
- busy  out  1  state ≠ IDLE.
- done  out  1  one-cycle pulse on transform completion.
- overflow  out  1  sticky: a result beat was dropped.

## Operation
- States: IDLE, LOAD, START, RUN, DRAIN.
- IDLE: go → LOAD; latch mode into core_mode; clear overflow, beat counters, buffer pointers.
- LOAD: in_ready=1. Each accepted beat (in_valid & in_ready) registers all lanes onto core_addr/core_din with core_we all-ones next cycle; otherwise core_we=0. After beat BEATS is accepted → START; in_ready drops the same edge.
- START: core_start=1 for exactly one cycle → RUN.
- RUN: each core_out_valid cycle writes core_dout into buffer and increments result count; at count BEATS → DRAIN. core_out_valid outside RUN ignored.
- Buffer full on a write: if out_valid & out_ready the same cycle, write accepted (occupancy unchanged); else beat dropped, overflow set, count still increments.
- DRAIN: when buffer empty → IDLE, done=1 that cycle.
- go outside IDLE ignored. Unload may proceed during RUN and DRAIN.
- Pointers ADDR bits log2(OBUF_DEPTH)+1 wide; wrap naturally; full/empty from MSB compare.

## Timing
- Reset (async assert, sync release): state IDLE; in_ready, core_we, core_start, core_mode, out_valid, busy, done, overflow = 0; core_addr, core_din, out_data = 0; counters and pointers 0.
- Load latency: accepted beat → core_we one cycle later; back-to-back beats sustain one beat per cycle.
- core_start asserts the cycle after the last core_we.
- Capture latency: core_out_valid at cycle t → out_valid at t+1 (buffer previously empty).
- out_data stable while out_valid & !out_ready.
- rst mid-transform: immediate abort to reset values; buffered data discarded.

## Test plan
- LANES=2, N_COEF=8, OBUF_DEPTH=4: go, mode=1, 4 beats addr 0..7 data 0x0100+addr → core_we=2'b11 four consecutive cycles, addresses (0,1),(2,3),(4,5),(6,7), core_mode=1, core_start one cycle after last write.
- in_valid toggled every other cycle during LOAD → exactly 4 writes, no duplicates; in_ready drops after 4th accept.
- Core returns 4 beats 0xA0+i with out_ready=1 → out_data 0xA0..0xA3 in order, done pulses once, busy falls same edge.
- out_ready=0, core returns 5 beats into depth 4 (N_COEF=10) → overflow=1, first 4 beats retained; same case with out_ready=1 on 5th beat → overflow stays 0.
- go asserted during RUN → no effect; rst asserted mid-LOAD → all outputs 0 next sample, new go restarts cleanly from beat 0.
